// File: rtl/ball_engine.sv
// Guitar Pong ball physics: tick divider, serve/play/point/over sequencing,
// paddle and wall bounces, scoring, packed into the 32-bit ball word.
module ball_engine #(
    parameter int TICK_DIV    = 1000000,
    parameter int BALL_VEL    = 3,
    parameter int SERVE_TICKS = 60,
    parameter int POINT_TICKS = 30,
    parameter int WIN_SCORE   = 7
) (
    input  logic        iVGA_CLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic [11:0] pL_ypos,
    input  logic [11:0] pR_ypos,
    output logic [31:0] ball,
    output logic        oPOINT_L,
    output logic        oPOINT_R
);
    localparam int CW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int PH_MAX = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int PW     = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;

    localparam logic [10:0] X_C    = 11'd310;
    localparam logic [10:0] Y_C    = 11'd230;
    localparam logic [10:0] X_MAX  = 11'd620;
    localparam logic [10:0] Y_MAX  = 11'd460;
    localparam logic [10:0] L_FACE = 11'd120;
    localparam logic [10:0] R_FACE = 11'd480;
    localparam logic [10:0] VEL    = 11'(BALL_VEL);
    localparam logic [3:0]  WIN    = 4'(WIN_SCORE);

    typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, POINT = 2'd2, OVER = 2'd3} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [10:0]     x_q, x_d, y_q, y_d;
    logic            dx_q, dx_d, dy_q, dy_d;
    logic [3:0]      scl_q, scl_d, scr_q, scr_d;
    logic            ptl_q, ptl_d, ptr_q, ptr_d;

    logic        tick;
    logic [10:0] nx, ny;
    logic [12:0] y_top, y_bot;
    logic        ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));
    assign nx   = dx_q ? x_q + VEL : x_q - VEL;
    assign ny   = dy_q ? y_q + VEL : y_q - VEL;

    // Overlap uses 13-bit sums so unclamped paddle positions cannot wrap.
    assign y_top = {2'b00, y_q};
    assign y_bot = {2'b00, y_q} + 13'd20;
    assign ovl_l = (y_bot > {1'b0, pL_ypos}) && (y_top < {1'b0, pL_ypos} + 13'd100);
    assign ovl_r = (y_bot > {1'b0, pR_ypos}) && (y_top < {1'b0, pR_ypos} + 13'd100);

    assign hit_l  = !dx_q && (x_q >= L_FACE) && (nx <= L_FACE) && ovl_l;
    assign hit_r  =  dx_q && (x_q <= R_FACE) && (nx >= R_FACE) && ovl_r;
    assign miss_l = !dx_q && (x_q < VEL);
    assign miss_r =  dx_q && (x_q + VEL > X_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        phase_d = phase_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        scl_d   = scl_q;
        scr_d   = scr_q;
        ptl_d   = 1'b0;
        ptr_d   = 1'b0;

        case (state_q)
            SERVE: if (tick) begin
                if (phase_q == PW'(SERVE_TICKS - 1)) begin
                    state_d = PLAY;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            PLAY: if (tick) begin
                if (!dy_q && (y_q < VEL)) begin
                    y_d  = '0;
                    dy_d = 1'b1;
                end else if (dy_q && (y_q + VEL > Y_MAX)) begin
                    y_d  = Y_MAX;
                    dy_d = 1'b0;
                end else begin
                    y_d = ny;
                end

                if (hit_l) begin
                    x_d  = L_FACE;
                    dx_d = 1'b1;
                end else if (hit_r) begin
                    x_d  = R_FACE;
                    dx_d = 1'b0;
                end else if (miss_l) begin
                    x_d   = '0;
                    scr_d = scr_q + 1'b1;
                    ptr_d = 1'b1;
                    state_d = (scr_q + 1'b1 == WIN) ? OVER : POINT;
                end else if (miss_r) begin
                    x_d   = X_MAX;
                    scl_d = scl_q + 1'b1;
                    ptl_d = 1'b1;
                    state_d = (scl_q + 1'b1 == WIN) ? OVER : POINT;
                end else begin
                    x_d = nx;
                end

                if (state_d == OVER) begin
                    x_d = X_C;
                    y_d = Y_C;
                end
            end
            // dx still points the way the ball left the field, i.e. at the loser.
            POINT: if (tick) begin
                if (phase_q == PW'(POINT_TICKS - 1)) begin
                    state_d = SERVE;
                    phase_d = '0;
                    x_d     = X_C;
                    y_d     = Y_C;
                    dy_d    = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            OVER: if (iSTART) begin
                state_d = SERVE;
                phase_d = '0;
                cnt_d   = '0;
                scl_d   = '0;
                scr_d   = '0;
                dx_d    = 1'b1;
                dy_d    = 1'b1;
            end
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            state_q <= SERVE;
            cnt_q   <= '0;
            phase_q <= '0;
            x_q     <= X_C;
            y_q     <= Y_C;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            scl_q   <= '0;
            scr_q   <= '0;
            ptl_q   <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            scl_q   <= scl_d;
            scr_q   <= scr_d;
            ptl_q   <= ptl_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ball     = {x_q, y_q, state_q, scl_q, scr_q};
    assign oPOINT_L = ptl_q;
    assign oPOINT_R = ptr_q;
endmodule

// File: tb/tb_ball_engine.sv
// Randomized bench for ball_engine: a tick-level game model predicts every
// cycle's ball word and point pulses; a monitor pops and compares them.
module tb_ball_engine;
    localparam int TD = 4, V = 3, ST = 2, PT = 2, WS = 2;

    logic        clk = 1'b0;
    logic        iRST = 1'b1, iSTART = 1'b0;
    logic [11:0] pL = 12'd0, pR = 12'd0;
    logic [31:0] ball;
    logic        oPOINT_L, oPOINT_R;

    ball_engine #(.TICK_DIV(TD), .BALL_VEL(V), .SERVE_TICKS(ST),
                  .POINT_TICKS(PT), .WIN_SCORE(WS)) dut (
        .iVGA_CLK(clk), .iRST(iRST), .iSTART(iSTART),
        .pL_ypos(pL), .pR_ypos(pR),
        .ball(ball), .oPOINT_L(oPOINT_L), .oPOINT_R(oPOINT_R));

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Game model: plain integers, ticks counted down rather than up.
    int m_x, m_y, m_st, m_sl, m_sr, m_cnt, m_wait;
    bit m_dx, m_dy, m_pl, m_pr, m_lastL;
    int cov_hitl = 0, cov_hitr = 0, cov_pts = 0, cov_over = 0, cov_restart = 0, cov_bounce = 0;
    logic [33:0] expq[$];

    function automatic bit overlap(int y, int py);
        return (y + 20 > py) && (y < py + 100);
    endfunction

    always @(posedge clk) begin
        int nx, ny_, nxo, nyo, score;
        bit tick, ndx, ndy, scored, left_scored;
        m_pl = 0; m_pr = 0;
        if (iRST) begin
            m_x = 310; m_y = 230; m_st = 0; m_sl = 0; m_sr = 0;
            m_dx = 1; m_dy = 1; m_cnt = 0; m_wait = ST;
        end else begin
            tick  = (m_cnt == TD - 1);
            m_cnt = (m_cnt + 1) % TD;
            if (m_st == 3) begin
                if (iSTART) begin
                    m_sl = 0; m_sr = 0; m_st = 0; m_wait = ST;
                    m_dx = 1; m_dy = 1; m_cnt = 0; cov_restart++;
                end
            end else if (tick) begin
                if (m_st == 0) begin
                    m_wait--;
                    if (m_wait == 0) m_st = 1;
                end else if (m_st == 2) begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_st = 0; m_wait = ST; m_x = 310; m_y = 230;
                        m_dx = m_lastL; m_dy = 1;
                    end
                end else begin
                    nx = m_dx ? m_x + V : m_x - V;
                    ny_ = m_dy ? m_y + V : m_y - V;
                    ndx = m_dx; ndy = m_dy; scored = 0; left_scored = 0;
                    if (!m_dy && m_y < V) begin nyo = 0; ndy = 1; end
                    else if (m_dy && m_y + V > 460) begin nyo = 460; ndy = 0; cov_bounce++; end
                    else nyo = ny_;
                    if (!m_dx && m_x >= 120 && nx <= 120 && overlap(m_y, pL)) begin
                        nxo = 120; ndx = 1; cov_hitl++;
                    end else if (m_dx && m_x <= 480 && nx >= 480 && overlap(m_y, pR)) begin
                        nxo = 480; ndx = 0; cov_hitr++;
                    end else if (!m_dx && m_x < V) begin
                        nxo = 0; scored = 1; left_scored = 0;
                    end else if (m_dx && m_x + V > 620) begin
                        nxo = 620; scored = 1; left_scored = 1;
                    end else nxo = nx;
                    m_x = nxo; m_y = nyo; m_dx = ndx; m_dy = ndy;
                    if (scored) begin
                        cov_pts++;
                        m_lastL = left_scored;
                        if (left_scored) begin m_sl++; m_pl = 1; score = m_sl; end
                        else begin m_sr++; m_pr = 1; score = m_sr; end
                        if (score == WS) begin
                            m_st = 3; m_x = 310; m_y = 230; cov_over++;
                        end else begin
                            m_st = 2; m_wait = PT;
                        end
                    end
                end
            end
        end
        expq.push_back({m_x[10:0], m_y[10:0], m_st[1:0], m_sl[3:0], m_sr[3:0], m_pl, m_pr});
    end

    always @(posedge clk) begin
        logic [33:0] e;
        #1;
        if (expq.size() == 0) begin
            check("queue_empty", 34'd1, 34'd0);
        end else begin
            e = expq.pop_front();
            check("ball", {2'b00, ball}, {2'b00, e[33:2]});
            check("pulses", {32'd0, oPOINT_L, oPOINT_R}, {32'd0, e[1:0]});
            check("y_le_460", 34'(ball[20:10] <= 11'd460), 34'd1);
        end
    end

    int mode = 0;
    bit mid_rst_done = 0;
    initial begin
        iRST = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ball", {2'b00, ball}, {2'b00, 11'd310, 11'd230, 10'd0});
        check("reset_pulses", {32'd0, oPOINT_L, oPOINT_R}, 34'd0);
        iRST = 1'b0;
        for (int cyc = 0; cyc < 24000; cyc++) begin
            if (cyc % 300 == 0) mode = $urandom_range(0, 3);
            case (mode)
                0, 1: begin
                    pL = (m_y < 40) ? 12'd0 : 12'(m_y - 40);
                    pR = pL;
                end
                2: begin
                    pL = 12'($urandom_range(0, 479));
                    pR = 12'($urandom_range(0, 479));
                end
                default: begin
                    pL = (m_y < 300) ? 12'd400 : 12'd0;
                    pR = pL;
                end
            endcase
            iSTART = (m_st == 3) && ($urandom_range(0, 7) == 0);
            iRST = ($urandom_range(0, 3999) == 0);
            if (!mid_rst_done && cyc > 8000 && m_st == 1 && m_cnt == TD - 1) begin
                iRST = 1'b1;
                mid_rst_done = 1;
                @(negedge clk);
                check("mid_play_reset", {ball, oPOINT_L, oPOINT_R},
                      {11'd310, 11'd230, 10'd0, 2'b00});
                iRST = 1'b0;
            end
            @(negedge clk);
        end
        iRST = 1'b0; iSTART = 1'b0;
        repeat (3) @(negedge clk);
        check("cov_left_hit",  34'(cov_hitl > 0), 34'd1);
        check("cov_right_hit", 34'(cov_hitr > 0), 34'd1);
        check("cov_point",     34'(cov_pts > 0), 34'd1);
        check("cov_over",      34'(cov_over > 0), 34'd1);
        check("cov_restart",   34'(cov_restart > 0), 34'd1);
        check("cov_bounce",    34'(cov_bounce > 0), 34'd1);
        check("cov_mid_reset", 34'(mid_rst_done), 34'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
